multdiv_fast_unit: RTL and testbench
====================================

Name: multdiv_fast_unit

Overview:
- RV32M multiply/divide datapath for the integer core's execute stage.
- Multiply uses a full 33x33 signed product in one cycle (or two, per parameter).
- Divide is a 36-cycle restoring long division that borrows the shared ALU adder through the operand outputs.
- Intermediate divide state lives in the core's external imd_val registers; this block supplies their next values and write enables.

Parameters:
- RV32M, default RV32MSingleCycle (ibex_pkg rv32m_e).
  - RV32MSingleCycle: multiply result valid in the enable cycle.
  - RV32MFast: multiply result registered, valid one cycle later.

Ports:
- clk_i  in  1  sole clock, rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- mult_en_i / div_en_i  in  1  operation active this cycle.
- mult_sel_i / div_sel_i  in  1  result mux select; one-hot, qualifies the matching enable.
- operator_i  in  md_op_e(2)  MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3.
- signed_mode_i  in  2  bit0: op_a signed; bit1: op_b signed.
- op_a_i / op_b_i  in  32  operands.
- alu_adder_ext_i  in  34  ({1'b0,alu_operand_a_o}+{1'b0,alu_operand_b_o}).
- alu_adder_i  in  32  alu_adder_ext_i[32:1].
- equal_to_zero_i  in  1  op_b_i==0.
- data_ind_timing_i  in  1  1 = constant-time divide.
- alu_operand_a_o / alu_operand_b_o  out  33  shared adder operands; bit0 of both =1 injects carry-in.
- imd_val_q_i[2]  in  34 each  registered intermediates.
- imd_val_d_o[2]  out  34 each  next intermediates.
- imd_val_we_o  out  2  per-entry write enables.
- multdiv_ready_id_i  in  1  consumer accepts result.
- multdiv_result_o  out  32  result.
- valid_o  out  1  result valid.

Behaviour:
- Reset: div FSM=MD_IDLE, counter=31, internal numerator/denominator regs=0, mult pipeline flag=0. Outputs are combinational and evaluate to valid_o=0, imd_val_we_o=0.
- Adder convention: subtract X-Y uses a={X,1}, b={~Y,1}; result in alu_adder_ext_i[32:1], borrow in bit 33. Negate X uses a={32'b0,1}, b={~X,1}. When no divide is active, alu_operand_a_o=alu_operand_b_o=0.
- Multiply: 33-bit sign/zero extension of each operand per signed_mode_i; 66-bit signed product.
  - MULL returns product[31:0]; MULH returns product[63:32].
  - SingleCycle: valid_o=mult_en_i&mult_sel_i combinationally.
  - Fast: first enabled cycle writes product low/high into imd_val_d_o[0][31:0]/[1][31:0] with we=2'b11; valid_o next cycle, result taken from imd_val_q_i; flag clears when multdiv_ready_id_i=1.
  - imd_val_we_o=0 in SingleCycle.
- Divide FSM, advances only while div_en_i&div_sel_i; either low returns the FSM to MD_IDLE next cycle (abort, no valid):
  - MD_IDLE: preload imd_val[0] (remainder/result) with 0xFFFFFFFF for DIV, op_a for REM; imd_val[1] (quotient) = 0; we=2'b11.
    - If equal_to_zero_i & !data_ind_timing_i, go to MD_FINISH.
    - Otherwise go to MD_ABS_A.
  - MD_ABS_A: numerator = |op_a| if signed_mode_i[0]&op_a[31], else op_a (negation via adder). Next MD_ABS_B.
  - MD_ABS_B: denominator = |op_b| likewise with bit1. Remainder=0. Next MD_COMP.
  - MD_COMP, 31 cycles, counter 31 down to 1:
    - Shift in numerator bit [counter]; trial = {rem,bit} - denominator.
    - If no borrow: rem=trial, quotient bit=1. Else rem={rem,bit}, bit=0.
    - At counter==1, go to MD_LAST.
  - MD_LAST: bit 0 iteration. Load imd_val[0] with quotient (DIV) or remainder (REM). Next MD_CHANGE_SIGN.
  - MD_CHANGE_SIGN: negate imd_val[0] via adder when needed, then MD_FINISH.
    - DIV: negate if sign_a^sign_b and op_b!=0.
    - REM: negate if sign_a.
  - MD_FINISH: valid_o=1, multdiv_result_o=imd_val_q_i[0][31:0]. When multdiv_ready_id_i, go to MD_IDLE; else hold.
- Latency: valid_o rises 36 cycles after the first enable cycle, or 1 cycle for early divide-by-zero.
- Corner results:
  - DIV by 0 = 0xFFFFFFFF; REM by 0 = op_a.
  - Signed 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - Result sign follows RISC-V truncation.
- Reset mid-operation aborts to the reset state the next cycle.

Optional Feature:
- MULTDIV_SVA_EN:
  - When defined: concurrent assertions check the following.
    - mult_sel_i & div_sel_i never both 1.
    - Div FSM never holds an undefined encoding.
    - valid_o is never X after reset.
    - MD_FINISH is reached exactly 36 cycles after the divide starts when data_ind_timing_i=1.
  - When undefined: no assertion code. Functional RTL is identical.

Decomposition:
- ibex_pkg holds md_op_e, rv32m_e and the div FSM enum md_fsm_e: MD_IDLE, MD_ABS_A, MD_ABS_B, MD_COMP, MD_LAST, MD_CHANGE_SIGN, MD_FINISH.
- One natural sub-module: multdiv_mult33, the combinational 33x33 signed multiplier.

Test Plan:
- Unsigned MULL 7*9, SingleCycle -> valid_o in the enable cycle, result 63.
- MULL a=-100 b=-3, signed_mode=11 -> 300. MULH 0xFFFFFFFF*0xFFFFFFFF, mode 00 -> 0xFFFFFFFE.
- DIV -100/7, signed_mode=01 -> valid after 36 cycles, result -14. REM same operands -> -2.
- DIV 5/0, data_ind_timing=0 -> valid next cycle, 0xFFFFFFFF. Same with data_ind_timing=1 -> 36 cycles, same value.
- Signed DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM -> 0.
- Drop div_en_i in MD_COMP, or assert rst_i -> MD_IDLE next cycle, valid_o stays 0. A new DIV 20/3 then returns 6.

Source files
------------

// File: rtl/ibex_pkg.sv
// ---------------------------------------------------------------------------
// ibex_pkg
// Shared types for the RV32M multiply/divide datapath.
//   md_op_e   : multiply/divide operation code (2 bits)
//   rv32m_e   : multiplier implementation select
//   md_fsm_e  : divide state machine encoding
//   md_ext33  : 32->33 bit sign/zero extension helper
// ---------------------------------------------------------------------------
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [0:0] {
        RV32MSingleCycle = 1'b0,
        RV32MFast        = 1'b1
    } rv32m_e;

    typedef enum logic [2:0] {
        MD_IDLE        = 3'd0,
        MD_ABS_A       = 3'd1,
        MD_ABS_B       = 3'd2,
        MD_COMP        = 3'd3,
        MD_LAST        = 3'd4,
        MD_CHANGE_SIGN = 3'd5,
        MD_FINISH      = 3'd6
    } md_fsm_e;

    // Counter start value: bit 31 is the first numerator bit shifted in.
    localparam logic [4:0] MD_CNT_INIT = 5'd31;

    // Extend a 32-bit operand to 33 bits, sign-extending when is_signed.
    function automatic logic [32:0] md_ext33(input logic [31:0] v, input logic is_signed);
        return {is_signed & v[31], v};
    endfunction

endpackage

// File: rtl/multdiv_mult33.sv
// ---------------------------------------------------------------------------
// multdiv_mult33
// Combinational 33x33 signed multiplier. Operands arrive already sign/zero
// extended, so one signed product covers every signedness combination.
//   op_a_i  in  33  multiplicand
//   op_b_i  in  33  multiplier
//   prod_o  out 66  signed product
// ---------------------------------------------------------------------------
module multdiv_mult33 (
    input  logic [32:0] op_a_i,
    input  logic [32:0] op_b_i,
    output logic [65:0] prod_o
);

    assign prod_o = $signed(op_a_i) * $signed(op_b_i);

endmodule

// File: rtl/multdiv_fast_unit.sv
// ---------------------------------------------------------------------------
// multdiv_fast_unit
// RV32M multiply/divide datapath for the execute stage.
//   - Multiply: one 33x33 signed product, result in the enable cycle
//     (RV32MSingleCycle) or one cycle later through imd_val (RV32MFast).
//   - Divide: 36-cycle restoring division using the shared ALU adder; the
//     remainder/result and quotient live in the core's imd_val registers.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mult_en_i/div_en_i           operation active this cycle
//   mult_sel_i/div_sel_i         one-hot result select
//   operator_i, signed_mode_i    operation and operand signedness
//   op_a_i, op_b_i               operands
//   alu_adder_ext_i/alu_adder_i  shared adder result (34-bit / [32:1])
//   equal_to_zero_i              op_b_i == 0
//   data_ind_timing_i            constant-time divide
//   alu_operand_a_o/_b_o         shared adder operands (bit0 = carry-in)
//   imd_val_q_i/_d_o/_we_o       external intermediate registers
//   multdiv_ready_id_i           consumer accepts result
//   multdiv_result_o, valid_o    result and its valid
// Build option: define MULTDIV_SVA_EN to compile concurrent assertions.
// ---------------------------------------------------------------------------
module multdiv_fast_unit
    import ibex_pkg::*;
#(
    parameter rv32m_e RV32M = RV32MSingleCycle
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mult_en_i,
    input  logic        div_en_i,
    input  logic        mult_sel_i,
    input  logic        div_sel_i,
    input  md_op_e      operator_i,
    input  logic [1:0]  signed_mode_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [33:0] alu_adder_ext_i,
    input  logic [31:0] alu_adder_i,
    input  logic        equal_to_zero_i,
    input  logic        data_ind_timing_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    input  logic [33:0] imd_val_q_i [2],
    output logic [33:0] imd_val_d_o [2],
    output logic [1:0]  imd_val_we_o,
    input  logic        multdiv_ready_id_i,
    output logic [31:0] multdiv_result_o,
    output logic        valid_o
);

    // ------------------------------------------------------------------
    // Multiply
    // ------------------------------------------------------------------
    logic [32:0] w_mult_a;
    logic [32:0] w_mult_b;
    logic [65:0] w_prod;
    logic        w_mult_active;
    logic        w_mult_hi;
    logic        w_mult_valid;
    logic        w_mult_we;
    logic [31:0] w_mult_result;
    logic [31:0] w_mult_imd [2];

    assign w_mult_a      = md_ext33(op_a_i, signed_mode_i[0]);
    assign w_mult_b      = md_ext33(op_b_i, signed_mode_i[1]);
    assign w_mult_active = mult_en_i & mult_sel_i;
    assign w_mult_hi     = (operator_i == MD_OP_MULH);
    assign w_mult_imd[0] = w_prod[31:0];
    assign w_mult_imd[1] = w_prod[63:32];

    multdiv_mult33 u_mult33 (
        .op_a_i (w_mult_a),
        .op_b_i (w_mult_b),
        .prod_o (w_prod)
    );

    generate
        if (RV32M == RV32MFast) begin : g_mult_fast
            // Set after the product has been parked in imd_val; the next
            // cycle presents it from there.
            logic r_mult_pending;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_mult_pending <= 1'b0;
                end else if (!w_mult_active) begin
                    r_mult_pending <= 1'b0;
                end else if (!r_mult_pending) begin
                    r_mult_pending <= 1'b1;
                end else if (multdiv_ready_id_i) begin
                    r_mult_pending <= 1'b0;
                end
            end

            assign w_mult_valid  = w_mult_active & r_mult_pending;
            assign w_mult_we     = w_mult_active & ~r_mult_pending;
            assign w_mult_result = w_mult_hi ? imd_val_q_i[1][31:0] : imd_val_q_i[0][31:0];
        end else begin : g_mult_single
            assign w_mult_valid  = w_mult_active;
            assign w_mult_we     = 1'b0;
            assign w_mult_result = w_mult_hi ? w_prod[63:32] : w_prod[31:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Divide
    // ------------------------------------------------------------------
    md_fsm_e     r_state;
    md_fsm_e     w_state_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_next;
    logic [31:0] r_num;
    logic [31:0] w_num_next;
    logic [31:0] r_den;
    logic [31:0] w_den_next;

    logic        w_div_active;
    logic        w_is_div;
    logic        w_sign_a;
    logic        w_sign_b;
    logic        w_need_neg;
    logic [31:0] w_rem;
    logic [31:0] w_quo;
    logic [31:0] w_trial_x;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [32:0] w_div_op_a;
    logic [32:0] w_div_op_b;
    logic [33:0] w_div_imd [2];
    logic [1:0]  w_div_we;
    logic        w_div_valid;

    assign w_div_active = div_en_i & div_sel_i;
    assign w_is_div     = (operator_i == MD_OP_DIV);
    assign w_sign_a     = signed_mode_i[0] & op_a_i[31];
    assign w_sign_b     = signed_mode_i[1] & op_b_i[31];
    assign w_rem        = imd_val_q_i[0][31:0];
    assign w_quo        = imd_val_q_i[1][31:0];

    // DIV by zero keeps the all-ones quotient; REM follows the dividend.
    assign w_need_neg = w_is_div ? ((w_sign_a ^ w_sign_b) & ~equal_to_zero_i) : w_sign_a;

    // The shifted remainder is 33 bits wide but the adder takes 32. When
    // rem[31] is set the shifted value is >= 2^32 > denominator, so the
    // subtraction always succeeds and its low 32 bits are exact.
    assign w_trial_x  = {w_rem[30:0], r_num[r_cnt]};
    assign w_ge       = w_rem[31] | alu_adder_ext_i[33];  // carry-out = no borrow
    assign w_rem_next = w_ge ? alu_adder_i : w_trial_x;
    assign w_quo_next = {w_quo[30:0], w_ge};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_num_next   = r_num;
        w_den_next   = r_den;
        w_div_op_a   = 33'd0;
        w_div_op_b   = 33'd0;
        w_div_imd[0] = 34'd0;
        w_div_imd[1] = 34'd0;
        w_div_we     = 2'b00;
        w_div_valid  = 1'b0;

        if (!w_div_active) begin
            // Dropping the enable aborts any divide in flight.
            w_state_next = MD_IDLE;
            w_cnt_next   = MD_CNT_INIT;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    w_div_imd[0] = {2'b00, (w_is_div ? 32'hFFFF_FFFF : op_a_i)};
                    w_div_imd[1] = 34'd0;
                    w_div_we     = 2'b11;
                    w_cnt_next   = MD_CNT_INIT;
                    w_state_next = (equal_to_zero_i && !data_ind_timing_i) ? MD_FINISH : MD_ABS_A;
                end
                MD_ABS_A: begin
                    w_div_op_a   = {32'd0, 1'b1};
                    w_div_op_b   = {~op_a_i, 1'b1};
                    w_num_next   = w_sign_a ? alu_adder_i : op_a_i;
                    w_state_next = MD_ABS_B;
                end
                MD_ABS_B: begin
                    w_div_op_a   = {32'd0, 1'b1};
                    w_div_op_b   = {~op_b_i, 1'b1};
                    w_den_next   = w_sign_b ? alu_adder_i : op_b_i;
                    w_div_imd[0] = 34'd0;
                    w_div_we     = 2'b01;
                    w_state_next = MD_COMP;
                end
                MD_COMP: begin
                    w_div_op_a   = {w_trial_x, 1'b1};
                    w_div_op_b   = {~r_den, 1'b1};
                    w_div_imd[0] = {2'b00, w_rem_next};
                    w_div_imd[1] = {2'b00, w_quo_next};
                    w_div_we     = 2'b11;
                    w_cnt_next   = r_cnt - 5'd1;
                    if (r_cnt == 5'd1) begin
                        w_state_next = MD_LAST;
                    end
                end
                MD_LAST: begin
                    // Counter is 0 here, so this is the bit-0 iteration.
                    w_div_op_a   = {w_trial_x, 1'b1};
                    w_div_op_b   = {~r_den, 1'b1};
                    w_div_imd[0] = {2'b00, (w_is_div ? w_quo_next : w_rem_next)};
                    w_div_we     = 2'b01;
                    w_state_next = MD_CHANGE_SIGN;
                end
                MD_CHANGE_SIGN: begin
                    w_div_op_a   = {32'd0, 1'b1};
                    w_div_op_b   = {~w_rem, 1'b1};
                    w_div_imd[0] = {2'b00, (w_need_neg ? alu_adder_i : w_rem)};
                    w_div_we     = 2'b01;
                    w_state_next = MD_FINISH;
                end
                MD_FINISH: begin
                    w_div_valid = 1'b1;
                    if (multdiv_ready_id_i) begin
                        w_state_next = MD_IDLE;
                    end
                end
                default: begin
                    w_state_next = MD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MD_IDLE;
            r_cnt   <= MD_CNT_INIT;
            r_num   <= 32'd0;
            r_den   <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_num   <= w_num_next;
            r_den   <= w_den_next;
        end
    end

    // ------------------------------------------------------------------
    // Output muxing
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_imd
            assign imd_val_d_o[gi] = w_div_active ? w_div_imd[gi] : {2'b00, w_mult_imd[gi]};
        end
    endgenerate

    assign imd_val_we_o     = w_div_active ? w_div_we : {2{w_mult_we}};
    assign alu_operand_a_o  = w_div_op_a;
    assign alu_operand_b_o  = w_div_op_b;
    assign multdiv_result_o = mult_sel_i ? w_mult_result : imd_val_q_i[0][31:0];
    assign valid_o          = w_mult_valid | w_div_valid;

    // Bits that exist on the interface but carry no information here.
    logic w_unused;
    assign w_unused = ^{alu_adder_ext_i[32:0], imd_val_q_i[0][33:32],
                        imd_val_q_i[1][33:32], w_prod[65:64]};

`ifdef MULTDIV_SVA_EN
    a_sel_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mult_sel_i && div_sel_i));

    a_state_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        r_state inside {MD_IDLE, MD_ABS_A, MD_ABS_B, MD_COMP,
                        MD_LAST, MD_CHANGE_SIGN, MD_FINISH});

    a_valid_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown(valid_o));

    a_div_const_time: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == MD_IDLE && w_div_active && data_ind_timing_i)
            ##1 (w_div_active [*35])
        |=> (r_state == MD_FINISH));
`endif

endmodule

// File: tb/tb_multdiv_fast_unit.sv
module tb_multdiv_fast_unit;
    import ibex_pkg::*;

    logic        clk;
    logic        rst;
    logic        mult_en, div_en, mult_sel, div_sel;
    md_op_e      operator;
    logic [1:0]  smode;
    logic [31:0] op_a, op_b;
    logic [33:0] adder_ext;
    logic [31:0] adder;
    logic        eq0;
    logic        dit;
    logic [32:0] opa, opb;
    logic [33:0] imd_q [2];
    logic [33:0] imd_d [2];
    logic [1:0]  imd_we;
    logic        ready;
    logic [31:0] result;
    logic        valid;

    int n_total = 0;
    int n_bad   = 0;

    multdiv_fast_unit dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mult_en_i          (mult_en),
        .div_en_i           (div_en),
        .mult_sel_i         (mult_sel),
        .div_sel_i          (div_sel),
        .operator_i         (operator),
        .signed_mode_i      (smode),
        .op_a_i             (op_a),
        .op_b_i             (op_b),
        .alu_adder_ext_i    (adder_ext),
        .alu_adder_i        (adder),
        .equal_to_zero_i    (eq0),
        .data_ind_timing_i  (dit),
        .alu_operand_a_o    (opa),
        .alu_operand_b_o    (opb),
        .imd_val_q_i        (imd_q),
        .imd_val_d_o        (imd_d),
        .imd_val_we_o       (imd_we),
        .multdiv_ready_id_i (ready),
        .multdiv_result_o   (result),
        .valid_o            (valid)
    );

    // Core-side environment: shared ALU adder and imd_val registers.
    assign adder_ext = {1'b0, opa} + {1'b0, opb};
    assign adder     = adder_ext[32:1];
    assign eq0       = (op_b == 32'd0);

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst)            imd_q[k] <= 34'd0;
            else if (imd_we[k]) imd_q[k] <= imd_d[k];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_mul(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] mode, input logic [31:0] exp);
        operator = op; op_a = a; op_b = b; smode = mode;
        mult_en = 1'b1; mult_sel = 1'b1;
        #1;
        chk({tag, ":valid"}, {31'd0, valid}, 32'd1);
        chk({tag, ":res"}, result, exp);
        chk({tag, ":we"}, {30'd0, imd_we}, 32'd0);
        $display("mul %s op=%0d a=%h b=%h mode=%b result=%h", tag, op, a, b, mode, result);
        step();
        mult_en = 1'b0; mult_sel = 1'b0;
        step();
    endtask

    task automatic do_div(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] mode, input logic t,
                          input logic [31:0] exp, input int exp_lat);
        int n;
        operator = op; op_a = a; op_b = b; smode = mode; dit = t;
        div_en = 1'b1; div_sel = 1'b1;
        #1;
        chk({tag, ":we0"}, {30'd0, imd_we}, 32'd3);
        n = 0;
        while (!valid && n < 80) begin
            step();
            n++;
        end
        chk({tag, ":lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ":res"}, result, exp);
        $display("div %s op=%0d a=%h b=%h mode=%b dit=%b result=%h cycles=%0d",
                 tag, op, a, b, mode, t, result, n);
        div_en = 1'b0; div_sel = 1'b0;
        step();
        chk({tag, ":idle"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; mult_en = 1'b0; div_en = 1'b0; mult_sel = 1'b0; div_sel = 1'b0;
        operator = MD_OP_MULL; smode = 2'b00; op_a = 32'd0; op_b = 32'd0;
        dit = 1'b0; ready = 1'b1;
        repeat (3) step();
        chk("rst:valid", {31'd0, valid}, 32'd0);
        chk("rst:we", {30'd0, imd_we}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle:valid", {31'd0, valid}, 32'd0);
        chk("idle:opa", opa[32:1], 32'd0);
        chk("idle:opb", opb[32:1], 32'd0);

        // Multiply (single-cycle build)
        do_mul("mull_7x9",    MD_OP_MULL, 32'd7,         32'd9,         2'b00, 32'd63);
        do_mul("mull_neg",    MD_OP_MULL, 32'hFFFF_FF9C, 32'hFFFF_FFFD, 2'b11, 32'd300);
        do_mul("mulhu_max",   MD_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFE);
        do_mul("mulh_m1m1",   MD_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'h0000_0000);
        do_mul("mulh_min2",   MD_OP_MULH, 32'h8000_0000, 32'h8000_0000, 2'b11, 32'h4000_0000);
        do_mul("mulhsu_m1",   MD_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'hFFFF_FFFF);

        // Divide
        do_div("div_m100_7",  MD_OP_DIV, 32'hFFFF_FF9C, 32'd7, 2'b01, 1'b0, 32'hFFFF_FFF2, 36);
        do_div("rem_m100_7",  MD_OP_REM, 32'hFFFF_FF9C, 32'd7, 2'b01, 1'b0, 32'hFFFF_FFFE, 36);
        do_div("div_100_m7",  MD_OP_DIV, 32'd100, 32'hFFFF_FFF9, 2'b11, 1'b0, 32'hFFFF_FFF2, 36);
        do_div("rem_100_m7",  MD_OP_REM, 32'd100, 32'hFFFF_FFF9, 2'b11, 1'b0, 32'd2, 36);
        do_div("div_5_0",     MD_OP_DIV, 32'd5, 32'd0, 2'b00, 1'b0, 32'hFFFF_FFFF, 1);
        do_div("rem_5_0",     MD_OP_REM, 32'd5, 32'd0, 2'b00, 1'b0, 32'd5, 1);
        do_div("div_5_0_ct",  MD_OP_DIV, 32'd5, 32'd0, 2'b00, 1'b1, 32'hFFFF_FFFF, 36);
        do_div("div_m7_0_ct", MD_OP_DIV, 32'hFFFF_FFF9, 32'd0, 2'b11, 1'b1, 32'hFFFF_FFFF, 36);
        do_div("rem_m7_0_ct", MD_OP_REM, 32'hFFFF_FFF9, 32'd0, 2'b11, 1'b1, 32'hFFFF_FFF9, 36);
        do_div("div_ovf",     MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'h8000_0000, 36);
        do_div("rem_ovf",     MD_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'd0, 36);
        do_div("divu_big",    MD_OP_DIV, 32'hFFFF_FFFF, 32'h0000_0010, 2'b00, 1'b0, 32'h0FFF_FFFF, 36);
        do_div("remu_big",    MD_OP_REM, 32'hFFFF_FFFF, 32'h0000_0010, 2'b00, 1'b0, 32'h0000_000F, 36);
        do_div("divu_hiden",  MD_OP_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00, 1'b0, 32'd1, 36);
        do_div("remu_hiden",  MD_OP_REM, 32'hFFFF_FFFF, 32'h8000_0000, 2'b00, 1'b0, 32'h7FFF_FFFF, 36);
        do_div("remu_maxden", MD_OP_REM, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'hFFFF_FFFE, 36);

        // Abort by dropping the enable mid-division
        operator = MD_OP_DIV; op_a = 32'd1000; op_b = 32'd7; smode = 2'b00; dit = 1'b0;
        div_en = 1'b1; div_sel = 1'b1;
        repeat (10) step();
        div_en = 1'b0;
        #1;
        chk("abort:valid", {31'd0, valid}, 32'd0);
        chk("abort:we", {30'd0, imd_we}, 32'd0);
        chk("abort:opb", opb[32:1], 32'd0);
        step();
        do_div("div_20_3_a",  MD_OP_DIV, 32'd20, 32'd3, 2'b00, 1'b0, 32'd6, 36);

        // Abort by reset mid-division (enable held high throughout)
        operator = MD_OP_DIV; op_a = 32'd1000; op_b = 32'd7; smode = 2'b00; dit = 1'b0;
        div_en = 1'b1; div_sel = 1'b1;
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("rstab:valid", {31'd0, valid}, 32'd0);
        step();
        rst = 1'b0;
        do_div("div_20_3_r",  MD_OP_DIV, 32'd20, 32'd3, 2'b00, 1'b0, 32'd6, 36);
        do_div("rem_20_3",    MD_OP_REM, 32'd20, 32'd3, 2'b00, 1'b0, 32'd2, 36);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
